// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one cache-line memory port between ICache refill and
// DCache refill/writeback, draining orphaned (flushed) ICache refills.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   ic_valid/ic_addr            ICache line-read request
//   ic_ready/ic_rdata           one-cycle completion pulse, registered line
//   dc_valid/dc_wr/dc_addr      DCache read or write request
//   dc_wdata                    DCache write line
//   dc_ready/dc_rdata           one-cycle completion pulse, registered line
//   mem_req/mem_wr/mem_addr     memory request, held until mem_ack
//   mem_wdata                   latched write line
//   mem_ack/mem_rdata           memory completion and read line
//
// Build option: define MEM_ARB_RR_EN for round-robin on IC/DC ties;
// otherwise DCache has fixed priority.
module mem_arbiter #(
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_valid,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_ready,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  input  logic                  dc_valid,
  input  logic                  dc_wr,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_ready,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state;
  logic   grant;
  logic   drop;
  logic   pick_dc;

`ifdef MEM_ARB_RR_EN
  logic   last_grant;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    pick_dc = dc_valid & (~ic_valid | ~last_grant);
  end
`else
  always_comb begin
    pick_dc = dc_valid;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_ready  <= 1'b0;
      dc_ready  <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ic_valid || dc_valid) begin
            grant     <= pick_dc;
            mem_addr  <= pick_dc ? dc_addr : ic_addr;
            mem_wr    <= pick_dc & dc_wr;
            mem_wdata <= pick_dc ? dc_wdata : '0;
            mem_req   <= 1'b1;
            drop      <= 1'b0;
            state     <= ISSUE;
`ifdef MEM_ARB_RR_EN
            last_grant <= pick_dc;
`endif
          end
        end
        ISSUE: begin
          // A flushed ICache refill is remembered so that its line is
          // swallowed when memory finally answers.
          if (!grant && !ic_valid) begin
            drop <= 1'b1;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (grant) begin
              if (!mem_wr) begin
                dc_rdata <= mem_rdata;
              end
              dc_ready <= 1'b1;
              state    <= RESP;
            end else begin
              ic_rdata <= mem_rdata;
              if (ic_valid && !drop) begin
                ic_ready <= 1'b1;
                state    <= RESP;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Expected memory requests and ready data are queued; a monitor checks them.
module tb_mem_arbiter;

  localparam int LW = 128;
  localparam int AW = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
  } mreq_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ic_valid = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic          ic_ready;
  logic [LW-1:0] ic_rdata;
  logic          dc_valid = 1'b0;
  logic          dc_wr = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic          dc_ready;
  logic [LW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int mem_wait = 0;

  mreq_t         mem_q[$];
  logic [LW-1:0] ic_q[$];
  logic [LW-1:0] dc_q[$];
  logic [LW-1:0] mem_line[logic [AW-1:0]];
  logic [LW-1:0] exp_dc_last = '0;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .ic_valid (ic_valid),
    .ic_addr  (ic_addr),
    .ic_ready (ic_ready),
    .ic_rdata (ic_rdata),
    .dc_valid (dc_valid),
    .dc_wr    (dc_wr),
    .dc_addr  (dc_addr),
    .dc_wdata (dc_wdata),
    .dc_ready (dc_ready),
    .dc_rdata (dc_rdata),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (mem_line.exists(a)) return mem_line[a];
    return {4{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: acks after mem_wait extra cycles, stores writes.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (rst || !mem_req) begin
        cnt = 0;
      end else if (cnt >= mem_wait) begin
        mem_ack = 1'b1;
        mem_rdata = line_of(mem_addr);
        if (mem_wr) mem_line[mem_addr] = mem_wdata;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  end

  // Monitor: compares every presented request/response against the queues.
  initial begin
    logic  prev_req = 1'b0;
    mreq_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (mem_q.size() == 0) begin
            fail_msg($sformatf("unexpected_mem_req addr=%h", mem_addr));
          end else begin
            cur = mem_q.pop_front();
            chk("mem_addr", LW'(mem_addr), LW'(cur.addr));
            chk("mem_wr", LW'(mem_wr), LW'(cur.wr));
            if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end else if (mem_req) begin
          chk("mem_addr_stable", LW'(mem_addr), LW'(cur.addr));
          chk("mem_wr_stable", LW'(mem_wr), LW'(cur.wr));
        end
        prev_req = mem_req;
        if (ic_ready) begin
          if (ic_q.size() == 0) fail_msg("unexpected_ic_ready");
          else chk("ic_rdata", ic_rdata, ic_q.pop_front());
        end
        if (dc_ready) begin
          if (dc_q.size() == 0) fail_msg("unexpected_dc_ready");
          else chk("dc_rdata", dc_rdata, dc_q.pop_front());
        end
        if (ic_ready && dc_ready) fail_msg("both_ready");
      end
    end
  end

  task automatic ic_req(input logic [AW-1:0] a);
    bit got = 0;
    ic_addr  = a;
    ic_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ic_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_msg("ic_ready_timeout");
    step();
    ic_valid = 1'b0;
  endtask

  task automatic dc_req(input logic [AW-1:0] a, input logic w,
                        input logic [LW-1:0] d);
    bit got = 0;
    dc_addr  = a;
    dc_wr    = w;
    dc_wdata = d;
    dc_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (dc_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_msg("dc_ready_timeout");
    step();
    dc_valid = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] aa;
    logic [LW-1:0] l33;
    int cyc;
    int ack_cyc;
    int rdy_cyc;
    aa  = {16{8'hAA}};
    l33 = {16{8'h33}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", LW'(mem_req), '0);
    chk("rst_ready", LW'({ic_ready, dc_ready}), '0);
    chk("rst_ic_rdata", ic_rdata, '0);
    chk("rst_dc_rdata", dc_rdata, '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    rst = 1'b0;
    step();

    // Minimum latency IC read
    mem_wait = 0;
    mem_line[32'h0000_1040] = l33;
    mem_q.push_back('{32'h0000_1040, 1'b0, '0});
    ic_q.push_back(l33);
    ic_addr  = 32'h0000_1040;
    ic_valid = 1'b1;
    step();
    chk("lat_mem_req_c1", LW'(mem_req), LW'(1));
    chk("lat_mem_addr_c1", LW'(mem_addr), LW'(32'h0000_1040));
    step();
    chk("lat_ic_ready_c2", LW'(ic_ready), LW'(1));
    chk("lat_dc_ready_c2", LW'(dc_ready), '0);
    chk("lat_ic_rdata_c2", ic_rdata, l33);
    step();
    ic_valid = 1'b0;
    step();

    // Tie, 2-cycle memory: DC write first, then IC
    mem_wait = 1;
    mem_q.push_back('{32'h200, 1'b1, aa});
    mem_q.push_back('{32'h100, 1'b0, '0});
    dc_q.push_back(exp_dc_last);
    ic_q.push_back(line_of(32'h100));
    fork
      ic_req(32'h100);
      dc_req(32'h200, 1'b1, aa);
    join
    step();

    // DC-only read of the written line, then a second tie
    mem_q.push_back('{32'h200, 1'b0, '0});
    dc_q.push_back(aa);
    exp_dc_last = aa;
    dc_req(32'h200, 1'b0, '0);
    step();
`ifdef MEM_ARB_RR_EN
    mem_q.push_back('{32'h140, 1'b0, '0});
    mem_q.push_back('{32'h180, 1'b0, '0});
`else
    mem_q.push_back('{32'h180, 1'b0, '0});
    mem_q.push_back('{32'h140, 1'b0, '0});
`endif
    ic_q.push_back(line_of(32'h140));
    dc_q.push_back(line_of(32'h180));
    exp_dc_last = line_of(32'h180);
    fork
      ic_req(32'h140);
      dc_req(32'h180, 1'b0, '0);
    join
    step();

    // IC flush: valid drops in 2nd ISSUE cycle, ack in 4th
    mem_wait = 3;
    mem_q.push_back('{32'h2C0, 1'b0, '0});
    ic_addr  = 32'h2C0;
    ic_valid = 1'b1;
    step();
    step();
    ic_valid = 1'b0;
    repeat (5) step();
    chk("drop_idle_mem_req", LW'(mem_req), '0);

    // Flush coinciding with mem_ack also drops
    mem_wait = 1;
    mem_q.push_back('{32'h2E0, 1'b0, '0});
    ic_addr  = 32'h2E0;
    ic_valid = 1'b1;
    step();
    step();
    ic_valid = 1'b0;
    repeat (4) step();
    chk("drop2_idle_mem_req", LW'(mem_req), '0);

    // Next IC request after a drop
    mem_wait = 0;
    mem_q.push_back('{32'h300, 1'b0, '0});
    ic_q.push_back(line_of(32'h300));
    ic_req(32'h300);
    step();

    // DC read with 5 wait cycles, address changes mid-wait
    mem_wait = 5;
    mem_q.push_back('{32'h400, 1'b0, '0});
    dc_q.push_back(line_of(32'h400));
    exp_dc_last = line_of(32'h400);
    dc_addr  = 32'h400;
    dc_wr    = 1'b0;
    dc_valid = 1'b1;
    cyc = 0;
    ack_cyc = -100;
    rdy_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) dc_addr = 32'h500;
      if (mem_ack) begin
        ack_cyc = cyc;
        chk("wait_mem_addr_at_ack", LW'(mem_addr), LW'(32'h400));
      end
      if (dc_ready) begin
        rdy_cyc = cyc;
        break;
      end
    end
    chk("wait_ready_after_ack", LW'(rdy_cyc - ack_cyc), LW'(1));
    step();
    dc_valid = 1'b0;
    step();

    // Reset mid-ISSUE, pending DC issued right after release
    mem_wait = 10;
    mem_q.push_back('{32'h600, 1'b0, '0});
    dc_addr  = 32'h600;
    dc_valid = 1'b1;
    step();
    step();
    @(negedge clk);
    #1;
    rst = 1'b1;
    dc_addr = 32'h700;
    #1;
    chk("midrst_mem_req", LW'(mem_req), '0);
    chk("midrst_ready", LW'({ic_ready, dc_ready}), '0);
    chk("midrst_ic_rdata", ic_rdata, '0);
    chk("midrst_dc_rdata", dc_rdata, '0);
    chk("midrst_mem_addr", LW'(mem_addr), '0);
    chk("midrst_mem_wdata", mem_wdata, '0);
    exp_dc_last = '0;
    repeat (2) @(negedge clk);
    mem_wait = 0;
    mem_q.push_back('{32'h700, 1'b0, '0});
    dc_q.push_back(line_of(32'h700));
    #1;
    rst = 1'b0;
    step();
    chk("postrst_mem_req", LW'(mem_req), LW'(1));
    chk("postrst_mem_addr", LW'(mem_addr), LW'(32'h700));
    dc_req(32'h700, 1'b0, '0);
    repeat (3) step();

    chk("mem_q_empty", LW'(mem_q.size()), '0);
    chk("ic_q_empty", LW'(ic_q.size()), '0);
    chk("dc_q_empty", LW'(dc_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
